maze_ram_loader: RTL

//  Copies one of NUM_MAZES maze layouts from the maze ROM into the display/game RAM.
//  - Scan order: raster order, x fastest then y.
//  - Each copy is started by a pulse. The maze to copy is selectable.
//  - ROM read latency is a parameter.
//  - While copying, the block finds the player start cell (START_COLOUR) and reports its coordinates.
//  - Sits between the maze ROM and the VGA/game RAM write port.
//  - Runs once per level load, before the game FSM leaves its LOAD state.

---
 rtl/maze_pkg.sv | 20 ++
 rtl/rom_tag_pipe.sv | 45 ++++
 rtl/maze_ram_loader.sv | 131 +++++++++++++
 3 files changed

// File: rtl/maze_pkg.sv
// Shared grid dimensions, colour codes and loader FSM states for the maze datapath.
package maze_pkg;

  localparam int unsigned GRID_W   = 32;
  localparam int unsigned GRID_H   = 32;
  localparam int unsigned COLOUR_W = 3;

  localparam logic [COLOUR_W-1:0] PATH         = COLOUR_W'(0);
  localparam logic [COLOUR_W-1:0] WALL         = COLOUR_W'(1);
  localparam logic [COLOUR_W-1:0] START_COLOUR = COLOUR_W'(2);
  localparam logic [COLOUR_W-1:0] GOAL         = COLOUR_W'(4);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rom_tag_pipe.sv
// Delays the {valid,x,y} tag of each ROM read by LAT cycles so it lines up with rom_data.
module rom_tag_pipe
  import maze_pkg::*;
#(
  parameter int unsigned LAT     = 1,
  parameter int unsigned COORD_W = 5
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               in_valid,
  input  logic [COORD_W-1:0] in_x,
  input  logic [COORD_W-1:0] in_y,
  output logic               out_valid,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y
);

  logic [LAT-1:0]     valid_q;
  logic [COORD_W-1:0] x_q [LAT];
  logic [COORD_W-1:0] y_q [LAT];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= '0;
      for (int i = 0; i < int'(LAT); i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      x_q[0]     <= in_x;
      y_q[0]     <= in_y;
      for (int i = 1; i < int'(LAT); i++) begin
        valid_q[i] <= valid_q[i-1];
        x_q[i]     <= x_q[i-1];
        y_q[i]     <= y_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[LAT-1];
  assign out_x     = x_q[LAT-1];
  assign out_y     = y_q[LAT-1];

endmodule

// File: rtl/maze_ram_loader.sv
// Copies a selected maze from ROM into game RAM in raster order and locates the player start cell.
module maze_ram_loader
  import maze_pkg::*;
#(
  parameter int unsigned GRID_W     = maze_pkg::GRID_W,
  parameter int unsigned GRID_H     = maze_pkg::GRID_H,
  parameter int unsigned COORD_W    = 5,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned COLOUR_W   = maze_pkg::COLOUR_W,
  parameter int unsigned MAZE_SEL_W = 2,
  parameter int unsigned ROM_LAT    = 1,
  parameter logic [COLOUR_W-1:0] START_COLOUR = maze_pkg::START_COLOUR
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [MAZE_SEL_W-1:0] maze_sel,
  output logic [MAZE_SEL_W-1:0] rom_maze,
  output logic [COORD_W-1:0]    rom_x,
  output logic [COORD_W-1:0]    rom_y,
  input  logic [COLOUR_W-1:0]   rom_data,
  output logic                  ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [COLOUR_W-1:0]   ram_data,
  output logic                  busy,
  output logic                  done,
  output logic                  start_found,
  output logic [COORD_W-1:0]    start_x,
  output logic [COORD_W-1:0]    start_y
);

  localparam int unsigned DRAIN_W = 3;

  state_t               state;
  logic [DRAIN_W-1:0]   drain_cnt;
  logic                 tag_valid;
  logic [COORD_W-1:0]   tag_x;
  logic [COORD_W-1:0]   tag_y;
  logic                 x_last;
  logic                 y_last;
  logic [ADDR_W-1:0]    tag_addr;

  rom_tag_pipe #(
    .LAT     (ROM_LAT),
    .COORD_W (COORD_W)
  ) u_tag_pipe (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (state == ISSUE),
    .in_x      (rom_x),
    .in_y      (rom_y),
    .out_valid (tag_valid),
    .out_x     (tag_x),
    .out_y     (tag_y)
  );

  // Write port follows the tag; gating with resetn stops writes in the reset cycle itself.
  assign ram_we   = tag_valid & resetn;
  assign tag_addr = ADDR_W'(tag_y) * ADDR_W'(GRID_W) + ADDR_W'(tag_x);
  assign ram_addr = ram_we ? tag_addr : '0;
  assign ram_data = ram_we ? rom_data : '0;

  assign x_last = (rom_x == COORD_W'(GRID_W - 1));
  assign y_last = (rom_y == COORD_W'(GRID_H - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      drain_cnt   <= '0;
      rom_maze    <= '0;
      rom_x       <= '0;
      rom_y       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      start_found <= 1'b0;
      start_x     <= '0;
      start_y     <= '0;
    end else begin
      // First start cell in raster order wins.
      if (ram_we && (rom_data == START_COLOUR) && !start_found) begin
        start_found <= 1'b1;
        start_x     <= tag_x;
        start_y     <= tag_y;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state       <= ISSUE;
            rom_maze    <= maze_sel;
            rom_x       <= '0;
            rom_y       <= '0;
            start_found <= 1'b0;
            start_x     <= '0;
            start_y     <= '0;
            busy        <= 1'b1;
          end
        end
        ISSUE: begin
          if (x_last) begin
            rom_x <= '0;
            if (y_last) begin
              rom_y     <= '0;
              state     <= DRAIN;
              drain_cnt <= DRAIN_W'(ROM_LAT - 1);
            end else begin
              rom_y <= rom_y + COORD_W'(1);
            end
          end else begin
            rom_x <= rom_x + COORD_W'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - DRAIN_W'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
